// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: ALUOp encodings, field widths and per-stage control bundles
// shared by the decoder, ALU control and the control pipeline.
package ctrl_pipe_pkg;
    localparam int REG_W   = 5;
    localparam int ALUOP_W = 2;
    localparam int CNT_W   = 16;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    typedef struct packed {
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } ex_ctrl_t;
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
    } mem_ctrl_t;
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;
    typedef struct packed {
        logic             valid;
        ex_ctrl_t         ex;
        mem_ctrl_t        mem;
        wb_ctrl_t         wb;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } id_ex_t;
    typedef struct packed {
        logic             valid;
        mem_ctrl_t        mem;
        wb_ctrl_t         wb;
        logic [REG_W-1:0] write_reg;
    } ex_mem_t;
    typedef struct packed {
        logic             valid;
        wb_ctrl_t         wb;
        logic [REG_W-1:0] write_reg;
    } mem_wb_t;
endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decoder-side inputs and staged control outputs of ctrl_pipe.
interface ctrl_pipe_if;
    import ctrl_pipe_pkg::*;
    logic               id_valid, reg_dst, alu_src, mem_to_reg, reg_write;
    logic               mem_read, mem_write, branch, mem_zero;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   id_rs, id_rt, id_rd;
    logic               ex_alu_src, ex_reg_dst, mem_mem_read, mem_mem_write;
    logic               wb_reg_write, wb_mem_to_reg, stall, flush;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [REG_W-1:0]   wb_write_reg;
    logic [CNT_W-1:0]   stall_count, flush_count;
    modport master (
        output id_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, mem_zero, alu_op, id_rs, id_rt, id_rd,
        input  ex_alu_src, ex_reg_dst, ex_alu_op, mem_mem_read, mem_mem_write,
               wb_reg_write, wb_mem_to_reg, wb_write_reg, stall, flush, stall_count, flush_count
    );
    modport slave (
        input  id_valid, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, mem_zero, alu_op, id_rs, id_rt, id_rd,
        output ex_alu_src, ex_reg_dst, ex_alu_op, mem_mem_read, mem_mem_write,
               wb_reg_write, wb_mem_to_reg, wb_write_reg, stall, flush, stall_count, flush_count
    );
endinterface

// File: rtl/ctrl_pipe_hazard_detect.sv
// hazard_detect: combinational load-use and taken-branch detection; a taken
// branch suppresses the stall because the dependent instruction is flushed.
module hazard_detect
    import ctrl_pipe_pkg::*;
(
    input  logic             id_valid_i,
    input  logic             id_alu_src_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic             mem_valid_i,
    input  logic             mem_branch_i,
    input  logic             mem_zero_i,
    output logic             stall_o,
    output logic             flush_o
);
    logic load_use;
    assign load_use = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rt_i != '0)
                    & ((ex_rt_i == id_rs_i) | ((ex_rt_i == id_rt_i) & ~id_alu_src_i));
    assign flush_o  = mem_valid_i & mem_branch_i & mem_zero_i;
    assign stall_o  = load_use & ~flush_o;
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM, MEM/WB control registers with load-use stall,
// branch flush and saturating stall/flush event counters.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    ctrl_pipe_if.slave bus
);
    id_ex_t           id_ex_q, id_ex_d;
    ex_mem_t          ex_mem_q, ex_mem_d;
    mem_wb_t          mem_wb_q, mem_wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
    logic             hz_stall, hz_flush, stall, flush, ex_on, mem_on, wb_on;

    hazard_detect u_hazard (
        .id_valid_i    (bus.id_valid),
        .id_alu_src_i  (bus.alu_src),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .ex_valid_i    (id_ex_q.valid),
        .ex_mem_read_i (id_ex_q.mem.mem_read),
        .ex_rt_i       (id_ex_q.rt),
        .mem_valid_i   (ex_mem_q.valid),
        .mem_branch_i  (ex_mem_q.mem.branch),
        .mem_zero_i    (bus.mem_zero),
        .stall_o       (hz_stall),
        .flush_o       (hz_flush)
    );

    assign stall = ~rst_i & hz_stall;
    assign flush = ~rst_i & hz_flush;

    always_comb begin
        id_ex_d  = (flush | stall | ~bus.id_valid) ? '0 : id_ex_t'{1'b1,
                   ex_ctrl_t'{bus.alu_src, bus.reg_dst, bus.alu_op},
                   mem_ctrl_t'{bus.mem_read, bus.mem_write, bus.branch},
                   wb_ctrl_t'{bus.reg_write, bus.mem_to_reg}, bus.id_rt, bus.id_rd};
        ex_mem_d = flush ? '0 : ex_mem_t'{id_ex_q.valid, id_ex_q.mem, id_ex_q.wb,
                   id_ex_q.ex.reg_dst ? id_ex_q.rd : id_ex_q.rt};
        mem_wb_d = mem_wb_t'{ex_mem_q.valid, ex_mem_q.wb, ex_mem_q.write_reg};
        stall_count_d = stall_count_q + CNT_W'(stall & ~&stall_count_q);
        flush_count_d = flush_count_q + CNT_W'(flush & ~&flush_count_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            mem_wb_q      <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            id_ex_q       <= id_ex_d;
            ex_mem_q      <= ex_mem_d;
            mem_wb_q      <= mem_wb_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // Stage outputs are forced low during reset, not just after it.
    assign ex_on  = ~rst_i & id_ex_q.valid;
    assign mem_on = ~rst_i & ex_mem_q.valid;
    assign wb_on  = ~rst_i & mem_wb_q.valid;

    assign bus.ex_alu_src    = ex_on & id_ex_q.ex.alu_src;
    assign bus.ex_reg_dst    = ex_on & id_ex_q.ex.reg_dst;
    assign bus.ex_alu_op     = {ALUOP_W{ex_on}} & id_ex_q.ex.alu_op;
    assign bus.mem_mem_read  = mem_on & ex_mem_q.mem.mem_read;
    assign bus.mem_mem_write = mem_on & ex_mem_q.mem.mem_write;
    assign bus.wb_reg_write  = wb_on & mem_wb_q.wb.reg_write;
    assign bus.wb_mem_to_reg = wb_on & mem_wb_q.wb.mem_to_reg;
    assign bus.wb_write_reg  = {REG_W{wb_on}} & mem_wb_q.write_reg;
    assign bus.stall         = stall;
    assign bus.flush         = flush;
    assign bus.stall_count   = stall_count_q;
    assign bus.flush_count   = flush_count_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: table-driven cycle vectors for ctrl_pipe plus hand sequences
// for counter saturation and reset during a stall.
module tb_ctrl_pipe;
    import ctrl_pipe_pkg::*;

    typedef struct packed {
        logic       v, reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
        logic [1:0] alu_op;
        logic [4:0] rs, rt, rd;
    } ins_t;

    typedef struct packed {
        ins_t       ins;
        logic       zero;
        logic [3:0] ex;
        logic [1:0] mem;
        logic [6:0] wb;
        logic       stall, flush;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    ctrl_pipe_if bus();
    ctrl_pipe dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [3:0] ex_act;
    logic [1:0] mem_act;
    logic [6:0] wb_act;
    assign ex_act  = {bus.ex_alu_src, bus.ex_reg_dst, bus.ex_alu_op};
    assign mem_act = {bus.mem_mem_read, bus.mem_mem_write};
    assign wb_act  = {bus.wb_reg_write, bus.wb_mem_to_reg, bus.wb_write_reg};

    localparam ins_t NOP = '0;

    function automatic ins_t rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return ins_t'{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT, rs, rt, rd};
    endfunction
    function automatic ins_t lw(logic [4:0] rs, logic [4:0] rt);
        return ins_t'{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALUOP_ADD, rs, rt, 5'd0};
    endfunction
    function automatic ins_t sw(logic [4:0] rs, logic [4:0] rt);
        return ins_t'{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD, rs, rt, 5'd0};
    endfunction
    function automatic ins_t beq(logic [4:0] rs, logic [4:0] rt);
        return ins_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB, rs, rt, 5'd0};
    endfunction
    function automatic ins_t inv(ins_t i);
        ins_t t = i;
        t.v = 1'b0;
        return t;
    endfunction
    function automatic vec_t row(ins_t i, logic z, logic [3:0] ex, logic [1:0] mem,
                                 logic [6:0] wb, logic s, logic f);
        return vec_t'{i, z, ex, mem, wb, s, f};
    endfunction

    task automatic drive(ins_t i, logic z);
        bus.id_valid   = i.v;
        bus.reg_dst    = i.reg_dst;
        bus.alu_src    = i.alu_src;
        bus.mem_to_reg = i.mem_to_reg;
        bus.reg_write  = i.reg_write;
        bus.mem_read   = i.mem_read;
        bus.mem_write  = i.mem_write;
        bus.branch     = i.branch;
        bus.alu_op     = i.alu_op;
        bus.id_rs      = i.rs;
        bus.id_rt      = i.rt;
        bus.id_rd      = i.rd;
        bus.mem_zero   = z;
    endtask

    task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all_zero(string name, int idx);
        chk({name, "_ex"}, idx, 16'(ex_act), 16'h0);
        chk({name, "_mem"}, idx, 16'(mem_act), 16'h0);
        chk({name, "_wb"}, idx, 16'(wb_act), 16'h0);
        chk({name, "_stall"}, idx, 16'(bus.stall), 16'h0);
        chk({name, "_flush"}, idx, 16'(bus.flush), 16'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // R-type latency
        tbl.push_back(row(rtype(1, 2, 5),  0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0110, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b1000101, 0, 0));
        // load-use via Rs: one stall, R-type re-presented
        tbl.push_back(row(lw(0, 8),        0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(rtype(8, 3, 6),  0, 4'b1000, 2'b00, 7'b0000000, 1, 0));
        tbl.push_back(row(rtype(8, 3, 6),  0, 4'b0000, 2'b10, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0110, 2'b00, 7'b1101000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b1000110, 0, 0));
        // taken branch kills the store and the R-type behind it
        tbl.push_back(row(beq(1, 2),       0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(sw(1, 4),        0, 4'b0001, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(rtype(1, 2, 7),  1, 4'b1000, 2'b00, 7'b0000000, 0, 1));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000010, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        // load-use coinciding with a taken branch: flush wins
        tbl.push_back(row(beq(1, 2),       0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(lw(0, 9),        0, 4'b0001, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(rtype(9, 0, 10), 1, 4'b1000, 2'b00, 7'b0000000, 0, 1));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000010, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        // $0 load and immediate-form store: no stall
        tbl.push_back(row(lw(1, 0),        0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(rtype(0, 0, 11), 0, 4'b1000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(lw(1, 9),        0, 4'b0110, 2'b10, 7'b0000000, 0, 0));
        tbl.push_back(row(sw(1, 9),        0, 4'b1000, 2'b00, 7'b1100000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b1000, 2'b10, 7'b1001011, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b01, 7'b1101001, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0001001, 0, 0));
        // untaken branch; invalid ID with matching Rs raises nothing
        tbl.push_back(row(beq(1, 2),       0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(lw(0, 3),        0, 4'b0001, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(inv(rtype(3, 3, 4)), 0, 4'b1000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b10, 7'b0000010, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b1100011, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        // load-use via Rt with register-form consumer
        tbl.push_back(row(lw(0, 8),        0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(rtype(2, 8, 12), 0, 4'b1000, 2'b00, 7'b0000000, 1, 0));
        tbl.push_back(row(rtype(2, 8, 12), 0, 4'b0000, 2'b10, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0110, 2'b00, 7'b1101000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b0000000, 0, 0));
        tbl.push_back(row(NOP,             0, 4'b0000, 2'b00, 7'b1001100, 0, 0));

        drive(rtype(8, 8, 1), 1'b1);
        tick();
        tick();
        chk_all_zero("reset", 0);
        chk("reset_stall_count", 0, bus.stall_count, 16'h0);
        chk("reset_flush_count", 0, bus.flush_count, 16'h0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].ins, tbl[k].zero);
            #1;
            chk("ex", k, 16'(ex_act), 16'(tbl[k].ex));
            chk("mem", k, 16'(mem_act), 16'(tbl[k].mem));
            chk("wb", k, 16'(wb_act), 16'(tbl[k].wb));
            chk("stall", k, 16'(bus.stall), 16'(tbl[k].stall));
            chk("flush", k, 16'(bus.flush), 16'(tbl[k].flush));
            tick();
        end
        chk("stall_count", 100, bus.stall_count, 16'd2);
        chk("flush_count", 100, bus.flush_count, 16'd2);

        // saturation: preload 0xFFFE, then two separate stalls
        drive(lw(0, 8), 1'b0);
        force dut.stall_count_q = 16'hFFFE;
        #1;
        release dut.stall_count_q;
        chk("sat_preload", 200, bus.stall_count, 16'hFFFE);
        tick();
        drive(rtype(8, 1, 2), 1'b0);
        #1;
        chk("sat_stall1", 201, 16'(bus.stall), 16'h1);
        tick();
        chk("sat_count1", 201, bus.stall_count, 16'hFFFF);
        drive(rtype(8, 1, 2), 1'b0);
        tick();
        drive(lw(0, 8), 1'b0);
        tick();
        drive(rtype(8, 1, 2), 1'b0);
        #1;
        chk("sat_stall2", 202, 16'(bus.stall), 16'h1);
        tick();
        chk("sat_count2", 202, bus.stall_count, 16'hFFFF);

        // reset asserted during a stall cycle
        drive(rtype(8, 1, 2), 1'b0);
        tick();
        drive(lw(0, 8), 1'b0);
        tick();
        drive(rtype(8, 1, 2), 1'b0);
        #1;
        chk("rst_pre_stall", 300, 16'(bus.stall), 16'h1);
        chk("rst_pre_ex", 300, 16'(ex_act), 16'(4'b1000));
        rst = 1'b1;
        #1;
        chk_all_zero("rst_during", 301);
        tick();
        rst = 1'b0;
        drive(NOP, 1'b0);
        #1;
        chk_all_zero("rst_after", 302);
        chk("rst_after_stall_count", 302, bus.stall_count, 16'h0);
        chk("rst_after_flush_count", 302, bus.flush_count, 16'h0);
        tick();
        chk_all_zero("rst_after2", 303);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 ID_Valid  input  1  decoder outputs and specifiers below hold a real instruction this cycle.
REQ-004 RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  input  1 each  decoder control bits for the instruction in ID.
REQ-005 ALUOp  input  2  decoder ALU class for the instruction in ID (00 add, 01 sub/compare, 10 funct-driven).
REQ-006 ID_Rs, ID_Rt, ID_Rd  input  5 each  register specifiers of the instruction in ID.
REQ-007 MEM_Zero  input  1  ALU zero flag of the instruction now in MEM.
REQ-008 EX_ALUSrc, EX_RegDst  output  1 each  EX-stage control.
REQ-009 EX_ALUOp  output  2  EX-stage ALU class.
REQ-010 MEM_MemRead, MEM_MemWrite  output  1 each  MEM-stage control.
REQ-011 WB_RegWrite, WB_MemtoReg  output  1 each  WB-stage control.
REQ-012 WB_WriteReg  output  5  destination register in WB.
REQ-013 Stall  output  1  freeze PC and IF/ID this cycle (combinational).
REQ-014 Flush  output  1  kill IF/ID contents this cycle (combinational).
REQ-015 StallCount, FlushCount  output  16 each  saturating event counters.

Function
REQ-016 Three control registers SHALL exist: ID/EX, EX/MEM, MEM/WB; each advances one stage per cycle.
REQ-017 Each stage register SHALL carry a valid bit; an invalid stage SHALL drive all its control outputs to 0.
REQ-018 EX stage SHALL compute WriteReg = RegDst ? Rd : Rt, carried to EX/MEM and MEM/WB; latency ID->WB_WriteReg = 3 cycles.
REQ-019 Branch taken = EX/MEM valid & Branch & MEM_Zero, combinational in the MEM cycle.
REQ-020 On branch taken: Flush=1; ID/EX and EX/MEM SHALL load bubbles (valid=0) at the next edge; MEM/WB advances normally.
REQ-021 Load-use hazard = ID_Valid & ID/EX valid & ID/EX MemRead & ID/EX Rt != 0 & (ID/EX Rt == ID_Rs | (ID/EX Rt == ID_Rt & !ALUSrc)).
REQ-022 On hazard without branch taken: Stall=1; ID/EX SHALL load a bubble; EX/MEM and MEM/WB advance; ID inputs are re-presented the next cycle.
REQ-023 Branch taken and hazard in the same cycle: flush wins; Stall=0, Flush=1.
REQ-024 Stall lasts exactly one cycle per load-use pair; a second consecutive stall SHALL NOT occur for the same pair.
REQ-025 ID_Valid=0 SHALL load a bubble into ID/EX; no hazard is raised.
REQ-026 StallCount and FlushCount SHALL each increment by 1 in every cycle where Stall / Flush is 1, saturating at 16'hFFFF (no wrap).
REQ-027 ALUOp SHALL be passed through unmodified; ctrl_pipe performs no funct decode.

Reset
REQ-028 Reset SHALL clear all three valid bits, all carried control bits, WriteReg and both counters to 0.
REQ-029 While Reset=1, Stall and Flush SHALL be 0 and all stage outputs 0.
REQ-030 Reset asserted mid-stall or mid-flush SHALL abandon the event; the first post-reset cycle starts with empty pipe.

Structure
REQ-031 Shared package SHALL hold the ALUOp encodings (00/01/10) and the per-stage control bundle field widths, shared with the decoder and ALU control.
REQ-032 One sub-module, hazard_detect, SHALL hold the purely combinational REQ-021/REQ-023 logic; ctrl_pipe holds all registers and counters.

Verification
REQ-033 R-type (RegDst=1, RegWrite=1, ALUOp=10, Rd=5) -> EX_ALUOp=10 at +1, WB_RegWrite=1 & WB_WriteReg=5 at +3.
REQ-034 Load Rt=8 then R-type Rs=8 -> Stall=1 for one cycle, one bubble in EX, StallCount=1, WB of R-type one cycle late.
REQ-035 Branch with MEM_Zero=1 in MEM -> Flush=1, the two younger instructions never assert MEM_MemWrite or WB_RegWrite, FlushCount=1.
REQ-036 Load-use hazard and branch taken in same cycle -> Flush=1, Stall=0, StallCount unchanged.
REQ-037 Load Rt=0 followed by use of $0 -> no stall; load to Rt=9 then store with Rt=9, ALUSrc=1 -> no stall.
REQ-038 Preload StallCount=16'hFFFE then two stalls -> counter holds 16'hFFFF; Reset mid-stall -> all outputs 0 next cycle.
